// File: rtl/sub_sequencer_pkg.sv
// Shared encodings for the slice-serial subtract sequencer:
// operation codes and controller states.
package sub_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_NEG = 2'b01,
        OP_CMP = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/sub_sequencer_subtractor.sv
// Narrow slice subtractor: a - b - borrow_in, borrow taken from the
// extended result's top bit.
module sub_sequencer_subtractor #(
    parameter int nrOfBits     = 8,
    parameter int extendedBits = 9
) (
    input  logic [nrOfBits-1:0] data_a,
    input  logic [nrOfBits-1:0] data_b,
    input  logic                borrow_in,
    output logic [nrOfBits-1:0] result,
    output logic                borrow_out
);

    logic [extendedBits-1:0] ext;

    assign ext        = extendedBits'(data_a) - extendedBits'(data_b) - extendedBits'(borrow_in);
    assign result     = ext[nrOfBits-1:0];
    assign borrow_out = ext[extendedBits-1];

endmodule

// File: rtl/sub_sequencer.sv
// Sequences one slice subtractor across a full word, LSB slice first,
// serving SUB / NEG / CMP for the control unit.
module sub_sequencer
    import sub_sequencer_pkg::*;
#(
    parameter int WORD_BITS  = 32,
    parameter int SLICE_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_BITS-1:0] operand_a,
    input  logic [WORD_BITS-1:0] operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_BITS-1:0] result,
    output logic                 negative,
    output logic                 zero,
    output logic                 borrow_out
);

    localparam int NSLICES = WORD_BITS / SLICE_BITS;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    state_e                 state, state_next;
    logic                   accept, step, finish, last;
    logic [IDX_W-1:0]       idx;
    logic                   borrow_q, zero_acc;
    logic [1:0]             op_q;
    logic [WORD_BITS-1:0]   a_q, b_q, shadow, word;
    logic [SLICE_BITS-1:0]  slice_a, slice_b, diff;
    logic                   slice_borrow;

    assign slice_a = a_q[idx*SLICE_BITS +: SLICE_BITS];
    assign slice_b = b_q[idx*SLICE_BITS +: SLICE_BITS];
    assign last    = (idx == IDX_W'(NSLICES - 1));
    assign done    = (state == DONE);

    sub_sequencer_subtractor #(
        .nrOfBits     (SLICE_BITS),
        .extendedBits (SLICE_BITS + 1)
    ) u_slice (
        .data_a     (slice_a),
        .data_b     (slice_b),
        .borrow_in  (borrow_q),
        .result     (diff),
        .borrow_out (slice_borrow)
    );

    // Full difference as it will look once the current slice is stored.
    always_comb begin
        word = shadow;
        word[idx*SLICE_BITS +: SLICE_BITS] = diff;
    end

    // The first RUN cycle after accept only primes busy; slices are
    // processed on the following NSLICES edges.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = busy;
                if (busy && last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            idx        <= '0;
            borrow_q   <= 1'b0;
            result     <= '0;
            negative   <= 1'b0;
            zero       <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state == RUN) && (state_next == RUN);
            if (accept) begin
                idx      <= '0;
                borrow_q <= 1'b0;
            end else if (step) begin
                idx      <= idx + IDX_W'(1);
                borrow_q <= slice_borrow;
            end
            if (finish) begin
                negative   <= word[WORD_BITS-1];
                zero       <= zero_acc && (diff == '0);
                borrow_out <= slice_borrow;
                if (op_q != OP_CMP)
                    result <= word;
            end
        end
    end

    // Operand copies and the working word carry no reset; accept initialises them.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_q      <= (op == OP_NEG) ? '0 : operand_a;
            b_q      <= operand_b;
            op_q     <= op;
            zero_acc <= 1'b1;
        end else if (step) begin
            shadow[idx*SLICE_BITS +: SLICE_BITS] <= diff;
            zero_acc <= zero_acc && (diff == '0);
        end
    end

endmodule
